// File: rtl/lsu_stage.sv
// Memory-access stage: takes the EX packet, runs at most one data-memory bus
// transaction for it and hands an aligned, extended write-back packet to WB.
module lsu_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_alu_result,
    input  logic [63:0] in_store_data,
    input  logic        in_mem_en,
    input  logic        in_mem_we,
    input  logic [1:0]  in_mem_size,
    input  logic        in_mem_unsigned,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_we,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [63:0] dmem_addr,
    output logic        dmem_we,
    output logic [7:0]  dmem_wstrb,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_resp_valid,
    input  logic [63:0] dmem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_wb_data,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_misalign
);
    // Handshake rule on both sides: a transfer happens on a rising edge where
    // valid and ready are both high; the sender holds its payload until then.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic        accept, misalign, do_mem, resp_take;
    logic [2:0]  off, off_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [7:0]  base_strb;
    logic [63:0] shifted, load_val;

    assign in_ready       = (state == IDLE) || (state == DONE && out_ready);
    assign accept         = in_valid && in_ready;
    assign dmem_req_valid = (state == REQ);
    assign out_valid      = (state == DONE);
    assign resp_take      = (state == WAIT) && dmem_resp_valid;
    assign off            = in_alu_result[2:0];
    assign do_mem         = in_mem_en && !misalign;

    always_comb begin
        misalign  = 1'b0;
        base_strb = 8'h01;
        case (in_mem_size)
            2'b00: begin misalign = 1'b0;      base_strb = 8'h01; end
            2'b01: begin misalign = off[0];    base_strb = 8'h03; end
            2'b10: begin misalign = |off[1:0]; base_strb = 8'h0F; end
            2'b11: begin misalign = |off;      base_strb = 8'hFF; end
            default: ;
        endcase
        misalign = misalign && in_mem_en;
    end

    // Load lane selection uses the latched offset; extension per latched size.
    assign shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_val = shifted;
        case (size_q)
            2'b00: load_val = unsigned_q ? {56'd0, shifted[7:0]}
                                         : {{56{shifted[7]}}, shifted[7:0]};
            2'b01: load_val = unsigned_q ? {48'd0, shifted[15:0]}
                                         : {{48{shifted[15]}}, shifted[15:0]};
            2'b10: load_val = unsigned_q ? {32'd0, shifted[31:0]}
                                         : {{32{shifted[31]}}, shifted[31:0]};
            2'b11: load_val = shifted;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = do_mem ? REQ : DONE;
                else if (state == DONE && out_ready)
                    state_next = IDLE;
            end
            REQ:  if (dmem_req_ready) state_next = WAIT;
            WAIT: if (dmem_resp_valid) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            off_q        <= 3'd0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            dmem_addr    <= 64'd0;
            dmem_we      <= 1'b0;
            dmem_wstrb   <= 8'd0;
            dmem_wdata   <= 64'd0;
            out_wb_data  <= 64'd0;
            out_rd       <= 5'd0;
            out_rd_we    <= 1'b0;
            out_misalign <= 1'b0;
        end else if (accept) begin
            off_q        <= off;
            size_q       <= in_mem_size;
            unsigned_q   <= in_mem_unsigned;
            dmem_addr    <= {in_alu_result[63:3], 3'b000};
            dmem_we      <= do_mem && in_mem_we;
            dmem_wstrb   <= (do_mem && in_mem_we) ? (base_strb << off) : 8'd0;
            dmem_wdata   <= (do_mem && in_mem_we) ? (in_store_data << {off, 3'b000}) : 64'd0;
            out_wb_data  <= in_alu_result;
            out_rd       <= in_rd;
            out_rd_we    <= in_rd_we && !misalign;
            out_misalign <= misalign;
        end else if (resp_take && !dmem_we) begin
            out_wb_data  <= load_val;
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: vector table for single ops plus hand-written
// sequences for back-to-back flow, backpressure and reset during WAIT.
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu_result;
    logic [63:0] in_store_data;
    logic        in_mem_en;
    logic        in_mem_we;
    logic [1:0]  in_mem_size;
    logic        in_mem_unsigned;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_addr;
    logic        dmem_we;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_wdata;
    logic        dmem_resp_valid;
    logic [63:0] dmem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_wb_data;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_misalign;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] sdata;
        logic        mem_en;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic        rd_we;
        logic [63:0] rdata;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_wb;
        logic        exp_mis;
        logic        exp_rd_we;
    } vec_t;

    vec_t vecs[14];

    lsu_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_mem_en(in_mem_en), .in_mem_we(in_mem_we), .in_mem_size(in_mem_size),
        .in_mem_unsigned(in_mem_unsigned), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_resp_valid(dmem_resp_valid),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_data(out_wb_data), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (dmem_req_valid && dmem_req_ready) hs_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_in(input vec_t v);
        in_valid        = 1'b1;
        in_alu_result   = v.alu;
        in_store_data   = v.sdata;
        in_mem_en       = v.mem_en;
        in_mem_we       = v.we;
        in_mem_size     = v.size;
        in_mem_unsigned = v.uns;
        in_rd           = v.rd;
        in_rd_we        = v.rd_we;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready), 64'd1);
        chk({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd0);
        chk({tag, "_addr"},      dmem_addr, 64'd0);
        chk({tag, "_we"},        64'(dmem_we), 64'd0);
        chk({tag, "_wstrb"},     64'(dmem_wstrb), 64'd0);
        chk({tag, "_wdata"},     dmem_wdata, 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_wb_data"},   out_wb_data, 64'd0);
        chk({tag, "_rd"},        64'(out_rd), 64'd0);
        chk({tag, "_rd_we"},     64'(out_rd_we), 64'd0);
        chk({tag, "_misalign"},  64'(out_misalign), 64'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_vec(input int idx);
        vec_t  v;
        string t;
        v = vecs[idx];
        t = $sformatf("v%0d", idx);
        drive_in(v);
        chk({t, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        if (v.exp_req) begin
            chk({t, "_req_valid"}, 64'(dmem_req_valid), 64'd1);
            chk({t, "_addr"},      dmem_addr, v.exp_addr);
            chk({t, "_we"},        64'(dmem_we), 64'(v.exp_we));
            chk({t, "_wstrb"},     64'(dmem_wstrb), 64'(v.exp_wstrb));
            chk({t, "_wdata"},     dmem_wdata, v.exp_wdata);
            chk({t, "_busy_in_ready"}, 64'(in_ready), 64'd0);
            dmem_req_ready = 1'b1;
            @(negedge clk);
            dmem_req_ready = 1'b0;
            chk({t, "_wait_req_valid"}, 64'(dmem_req_valid), 64'd0);
            chk({t, "_wait_out_valid"}, 64'(out_valid), 64'd0);
            dmem_resp_valid = 1'b1;
            dmem_rdata      = v.rdata;
            @(negedge clk);
            dmem_resp_valid = 1'b0;
        end else begin
            chk({t, "_no_req"}, 64'(dmem_req_valid), 64'd0);
        end
        chk({t, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({t, "_wb_data"},   out_wb_data, v.exp_wb);
        chk({t, "_rd"},        64'(out_rd), 64'(v.rd));
        chk({t, "_rd_we"},     64'(out_rd_we), 64'(v.exp_rd_we));
        chk({t, "_misalign"},  64'(out_misalign), 64'(v.exp_mis));
        @(negedge clk);
        chk({t, "_idle_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        //          alu                    sdata                  en we sz un rd  rwe rdata                  req addr                   we strb   wdata                  wb                     mis rwe
        vecs[0]  = '{64'h1234,             64'h0,                 0, 0, 0, 0, 5,  1, 64'h0,                 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h1234,              0, 1};
        vecs[1]  = '{64'h8000_0003,        64'h0,                 1, 0, 0, 0, 7,  1, 64'h0000_0000_8000_0000, 1, 64'h8000_0000,      0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 0, 1};
        vecs[2]  = '{64'h8000_0003,        64'h0,                 1, 0, 0, 1, 7,  1, 64'h0000_0000_8000_0000, 1, 64'h8000_0000,      0, 8'h00, 64'h0,                 64'h80,                0, 1};
        vecs[3]  = '{64'h8000_0004,        64'hDEAD_BEEF,         1, 1, 2, 0, 0,  0, 64'h1111,              1, 64'h8000_0000,         1, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h8000_0004,       0, 0};
        vecs[4]  = '{64'h8000_0001,        64'h0,                 1, 0, 1, 0, 9,  1, 64'h0,                 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h8000_0001,         1, 0};
        vecs[5]  = '{64'h1006,             64'h0,                 1, 0, 1, 0, 3,  1, 64'h8123_4567_89AB_CDEF, 1, 64'h1000,            0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_8123, 0, 1};
        vecs[6]  = '{64'h2004,             64'h0,                 1, 0, 2, 1, 4,  1, 64'h89AB_CDEF_0123_4567, 1, 64'h2000,            0, 8'h00, 64'h0,                 64'h0000_0000_89AB_CDEF, 0, 1};
        vecs[7]  = '{64'h2004,             64'h0,                 1, 0, 2, 0, 4,  1, 64'h89AB_CDEF_0123_4567, 1, 64'h2000,            0, 8'h00, 64'h0,                 64'hFFFF_FFFF_89AB_CDEF, 0, 1};
        vecs[8]  = '{64'h3008,             64'h0,                 1, 0, 3, 1, 6,  1, 64'hFEDC_BA98_7654_3210, 1, 64'h3008,            0, 8'h00, 64'h0,                 64'hFEDC_BA98_7654_3210, 0, 1};
        vecs[9]  = '{64'h4005,             64'h1122_3344_5566_77AB, 1, 1, 0, 0, 0, 0, 64'h0,               1, 64'h4000,              1, 8'h20, 64'h6677_AB00_0000_0000, 64'h4005,            0, 0};
        vecs[10] = '{64'h5002,             64'hCAFE,              1, 1, 1, 0, 0,  0, 64'h0,                 1, 64'h5000,              1, 8'h0C, 64'hCAFE_0000,          64'h5002,              0, 0};
        vecs[11] = '{64'h6006,             64'h55,                1, 1, 2, 0, 2,  1, 64'h0,                 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h6006,              1, 0};
        vecs[12] = '{64'h7004,             64'h0,                 1, 0, 3, 0, 8,  1, 64'h0,                 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h7004,              1, 0};
        vecs[13] = '{64'h8000,             64'h0123_4567_89AB_CDEF, 1, 1, 3, 0, 0, 0, 64'h0,               1, 64'h8000,              1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h8000,            0, 0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_alu_result = '0; in_store_data = '0; in_mem_en = 1'b0;
        in_mem_we = 1'b0; in_mem_size = 2'd0; in_mem_unsigned = 1'b0;
        in_rd = '0; in_rd_we = 1'b0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(i);

        // Back-to-back pass-through: one result per cycle.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_mem_en = 1'b0; in_rd_we = 1'b1;
            in_alu_result = 64'h100 + 64'(i);
            in_rd = 5'(i + 1);
            @(negedge clk);
            chk($sformatf("b2b%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("b2b%0d_wb_data", i), out_wb_data, 64'h100 + 64'(i));
            chk($sformatf("b2b%0d_rd", i), 64'(out_rd), 64'(i + 1));
            chk($sformatf("b2b%0d_in_ready", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end_out_valid", 64'(out_valid), 64'd0);

        // Backpressure on both sides; stray responses outside WAIT ignored.
        hs_cnt = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b1; in_mem_size = 2'd2;
        in_alu_result = 64'h9000_000C; in_store_data = 64'h1234_5678;
        in_rd = 5'd0; in_rd_we = 1'b0;
        @(negedge clk);
        in_alu_result = 64'hFFFF_FFFF; in_store_data = 64'hBAD; in_mem_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_req%0d_valid", i), 64'(dmem_req_valid), 64'd1);
            chk($sformatf("bp_req%0d_addr", i), dmem_addr, 64'h9000_0008);
            chk($sformatf("bp_req%0d_wstrb", i), 64'(dmem_wstrb), 64'hF0);
            chk($sformatf("bp_req%0d_wdata", i), dmem_wdata, 64'h1234_5678_0000_0000);
            chk($sformatf("bp_req%0d_in_ready", i), 64'(in_ready), 64'd0);
            dmem_resp_valid = (i == 1);
            @(negedge clk);
        end
        dmem_req_ready = 1'b1;
        dmem_resp_valid = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b0;
        chk("bp_wait_req_valid", 64'(dmem_req_valid), 64'd0);
        chk("bp_early_resp_ignored", 64'(out_valid), 64'd0);
        chk("bp_wait_in_ready", 64'(in_ready), 64'd0);
        dmem_resp_valid = 1'b1;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_done%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_done%0d_wb_data", i), out_wb_data, 64'h9000_000C);
            if (i < 2) chk($sformatf("bp_done%0d_in_ready", i), 64'(in_ready), 64'd0);
            if (i == 2) begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_handshakes", 64'(hs_cnt), 64'd1);

        // Reset while waiting for a response.
        in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b0; in_mem_size = 2'd3;
        in_alu_result = 64'h100; in_rd = 5'd12; in_rd_we = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rw_req_valid", 64'(dmem_req_valid), 64'd1);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outputs("rw");
        dmem_resp_valid = 1'b1;
        dmem_rdata = 64'hAAAA_5555;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        chk("rw_after_out_valid", 64'(out_valid), 64'd0);
        chk("rw_after_in_ready", 64'(in_ready), 64'd1);
        chk("rw_after_wb_data", out_wb_data, 64'd0);
        @(negedge clk);
        chk("rw_late_out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_stage.md
# lsu_stage

Memory-access stage directly downstream of the ALU in the NPC pipeline. It accepts the ALU result plus memory-op controls from EX, and for loads/stores uses the ALU result as the effective address. It drives a valid/ready data-memory bus, aligns and extends load data, builds store strobes, and hands a write-back packet to WB. Non-memory ops pass the ALU result straight through.

## Interface
Parameters: none (XLEN fixed at 64, bus 64-bit, 8-byte aligned).

Ports (reset is synchronous, active-low, sampled on `clk` rising edge):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EX packet valid
- in_ready  out  1  stage can accept a packet this cycle
- in_alu_result  in  64  ALU result; effective address when in_mem_en=1
- in_store_data  in  64  rs2 value for stores
- in_mem_en  in  1  op is a load or store
- in_mem_we  in  1  1=store, 0=load (valid when in_mem_en)
- in_mem_size  in  2  00 byte, 01 half, 10 word, 11 double
- in_mem_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- in_rd  in  5  destination register
- in_rd_we  in  1  register write enable
- dmem_req_valid  out  1  bus request valid
- dmem_req_ready  in  1  bus accepts request
- dmem_addr  out  64  {in_alu_result[63:3], 3'b000}
- dmem_we  out  1  write request
- dmem_wstrb  out  8  byte strobes
- dmem_wdata  out  64  lane-shifted store data
- dmem_resp_valid  in  1  read data / write ack valid (one cycle)
- dmem_rdata  in  64  read data
- out_valid  out  1  WB packet valid
- out_ready  in  1  WB accepts packet
- out_wb_data  out  64  write-back value
- out_rd  out  5  destination register
- out_rd_we  out  1  write enable (forced 0 on misalign)
- out_misalign  out  1  access was misaligned, no bus activity performed

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept (in_valid & in_ready) latches all inputs, then:
  - in_mem_en=0 -> DONE, out_wb_data=in_alu_result.
  - misaligned (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0) -> DONE, out_misalign=1, out_rd_we=0, out_wb_data=in_alu_result, no bus request.
  - else -> REQ.
- REQ: dmem_req_valid=1, addr/we/wstrb/wdata stable until dmem_req_ready; handshake -> WAIT.
- WAIT: dmem_resp_valid -> DONE. Load: out_wb_data = extend((dmem_rdata >> 8*off)[size]), off=addr[2:0]; sign-extend unless in_mem_unsigned (double ignores unsigned). Store: out_wb_data=in_alu_result.
- Store: wstrb = base<<off (base 0x01/0x03/0x0F/0xFF by size); wdata = in_store_data << 8*off. Load: wstrb=0, wdata=0.
- DONE: out_valid=1, packet stable until out_ready. out_ready & in_valid -> accept new packet same cycle (back-to-back); out_ready & !in_valid -> IDLE.
- dmem_resp_valid outside WAIT is ignored.

## Timing
- All outputs registered or decoded from registered state; no combinational in_* -> out_* path. in_ready and dmem_req_valid depend only on state and out_ready.
- Reset values: in_ready=1 (IDLE), dmem_req_valid=0, dmem_addr=0, dmem_we=0, dmem_wstrb=0, dmem_wdata=0, out_valid=0, out_wb_data=0, out_rd=0, out_rd_we=0, out_misalign=0.
- Non-mem/misaligned: accept cycle N -> out_valid cycle N+1.
- Mem: accept N -> dmem_req_valid N+1; ready at N+1 -> WAIT N+2; resp at N+2 -> out_valid N+3. Response in the same cycle as the request handshake is not accepted.
- Sustained throughput: one non-mem op per cycle when out_ready held high.
- Reset mid-operation (REQ/WAIT/DONE): next cycle IDLE with reset outputs; outstanding request dropped, later response ignored.

## Test plan
- Pass-through: in_mem_en=0, alu_result=0x1234, rd=5, rd_we=1, out_ready=1 -> out_valid one cycle later, out_wb_data=0x1234, rd=5; 4 back-to-back ops emerge on 4 consecutive cycles.
- Signed byte load: addr=0x8000_0003, size=00, unsigned=0, rdata=0x0000_0000_8000_0000 -> dmem_addr=0x8000_0000, out_wb_data=0xFFFF_FFFF_FFFF_FF80; with unsigned=1 -> 0x80.
- Word store: addr=0x8000_0004, size=10, store_data=0xDEAD_BEEF -> dmem_we=1, wstrb=0xF0, wdata=0xDEAD_BEEF_0000_0000; out_valid after resp.
- Misalign: half load at 0x8000_0001 -> no dmem_req_valid, out_misalign=1, out_rd_we=0, out_valid next cycle.
- Backpressure: dmem_req_ready low 3 cycles then high, out_ready low 2 cycles in DONE -> request and packet held stable, in_ready=0 throughout, single bus transaction.
- Reset in WAIT: rst_n low 1 cycle, then dmem_resp_valid pulses -> all outputs at reset values, no out_valid, in_ready=1.
